// File: rtl/div_sequencer_pkg.sv
// Shared constants for the RV32M divide sequencer: ALU select codes,
// FSM state encoding and op-class helpers.
package div_sequencer_pkg;

  localparam logic [4:0] ALU_DIV  = 5'b01111;
  localparam logic [4:0] ALU_DIVU = 5'b10000;
  localparam logic [4:0] ALU_REM  = 5'b10001;
  localparam logic [4:0] ALU_REMU = 5'b10010;

  localparam logic [31:0] INT_MIN  = 32'h8000_0000;
  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

  localparam int CNT_W = 5;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_FIN  = 2'd2
  } div_state_e;

  function automatic logic is_div_op(input logic [4:0] sel);
    return (sel == ALU_DIV) || (sel == ALU_DIVU) || (sel == ALU_REM) || (sel == ALU_REMU);
  endfunction

  function automatic logic is_signed_op(input logic [4:0] sel);
    return (sel == ALU_DIV) || (sel == ALU_REM);
  endfunction

  function automatic logic is_rem_op(input logic [4:0] sel);
    return (sel == ALU_REM) || (sel == ALU_REMU);
  endfunction

endpackage

// File: rtl/div_sequencer_div_step.sv
// One radix-2 restoring division iteration; purely combinational so it can
// be chained for a multi-bit-per-cycle variant.
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN:0]   shifted;
  logic [XLEN-1:0] diff;
  logic            ge;

  // Compare on XLEN+1 bits so the shifted-out top bit of rem is not lost.
  assign shifted = {rem_i, quo_i[XLEN-1]};
  assign ge      = shifted >= {1'b0, divisor_i};
  assign diff    = shifted[XLEN-1:0] - divisor_i;

  always_comb begin
    rem_o = shifted[XLEN-1:0];
    quo_o = {quo_i[XLEN-2:0], 1'b0};
    if (ge) begin
      rem_o = diff;
      quo_o = {quo_i[XLEN-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_sequencer.sv
// EX-stage multi-cycle DIV/DIVU/REM/REMU sequencer: 32-step restoring divide
// with RISC-V special cases, registered RESULT and a one-cycle DONE pulse.
module div_sequencer
  import div_sequencer_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            START,
  input  logic [4:0]      SELECT,
  input  logic [XLEN-1:0] DATA1,
  input  logic [XLEN-1:0] DATA2,
  input  logic            FLUSH,
  output logic            BUSY,
  output logic            DONE,
  output logic [XLEN-1:0] RESULT
);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       op_q, op_d;
  logic [XLEN-1:0]  rem_q, rem_d, quo_q, quo_d, dvsr_q, dvsr_d, result_q, result_d;
  logic             neg_q_q, neg_q_d, neg_r_q, neg_r_d;

  logic            sgn;
  logic [XLEN-1:0] a_abs, b_abs, step_rem, step_quo, q_fix, r_fix;

  assign sgn   = is_signed_op(SELECT);
  assign a_abs = (sgn && DATA1[XLEN-1]) ? (~DATA1 + 1'b1) : DATA1;
  assign b_abs = (sgn && DATA2[XLEN-1]) ? (~DATA2 + 1'b1) : DATA2;
  assign q_fix = neg_q_q ? (~step_quo + 1'b1) : step_quo;
  assign r_fix = neg_r_q ? (~step_rem + 1'b1) : step_rem;

  div_step #(.XLEN(XLEN)) u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (dvsr_q),
    .rem_o     (step_rem),
    .quo_o     (step_quo)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvsr_d   = dvsr_q;
    result_d = result_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;
    unique case (state_q)
      DIV_IDLE: begin
        if (START && !FLUSH && is_div_op(SELECT)) begin
          op_d    = SELECT;
          dvsr_d  = b_abs;
          neg_q_d = sgn & (DATA1[XLEN-1] ^ DATA2[XLEN-1]);
          neg_r_d = sgn & DATA1[XLEN-1];
          if (DATA2 == '0) begin
            result_d = is_rem_op(SELECT) ? DATA1 : ALL_ONES;
            state_d  = DIV_FIN;
          end else if (sgn && DATA1 == INT_MIN && DATA2 == ALL_ONES) begin
            result_d = is_rem_op(SELECT) ? '0 : INT_MIN;
            state_d  = DIV_FIN;
          end else begin
            rem_d   = '0;
            quo_d   = a_abs;
            cnt_d   = 5'd31;
            state_d = DIV_CALC;
          end
        end
      end
      DIV_CALC: begin
        if (FLUSH) begin
          state_d = DIV_IDLE;
        end else begin
          rem_d = step_rem;
          quo_d = step_quo;
          if (cnt_q == '0) begin
            result_d = is_rem_op(op_q) ? r_fix : q_fix;
            state_d  = DIV_FIN;
          end else begin
            cnt_d = cnt_q - 5'd1;
          end
        end
      end
      DIV_FIN:  state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= DIV_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      result_q <= '0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvsr_q   <= dvsr_d;
      result_q <= result_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
    end
  end

  assign BUSY   = (state_q != DIV_IDLE);
  assign DONE   = (state_q == DIV_FIN);
  assign RESULT = result_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Bench for div_sequencer: directed vector table, flush/reset sequences and
// random ops against an arithmetic reference model.
module tb_div_sequencer;
  import div_sequencer_pkg::*;

  logic        CLK = 1'b0;
  logic        RESET, START, FLUSH, BUSY, DONE;
  logic [4:0]  SELECT;
  logic [31:0] DATA1, DATA2, RESULT;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  div_sequencer #(.XLEN(32)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .SELECT(SELECT),
    .DATA1(DATA1), .DATA2(DATA2), .FLUSH(FLUSH),
    .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT)
  );

  typedef struct {
    logic [4:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model straight from the RISC-V M-extension rules.
  function automatic logic [31:0] ref_div(input logic [4:0] sel, input logic [31:0] a,
                                          input logic [31:0] b);
    int sa, sb;
    sa = int'(a);
    sb = int'(b);
    case (sel)
      ALU_DIV:  return (b == 0) ? ALL_ONES : (a == INT_MIN && b == ALL_ONES) ? INT_MIN : 32'(sa / sb);
      ALU_REM:  return (b == 0) ? a : (a == INT_MIN && b == ALL_ONES) ? 32'd0 : 32'(sa % sb);
      ALU_DIVU: return (b == 0) ? ALL_ONES : a / b;
      default:  return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b);
    if (b == 0) return 1;
    if ((sel == ALU_DIV || sel == ALU_REM) && a == INT_MIN && b == ALL_ONES) return 1;
    return 33;
  endfunction

  // Start at edge k, watch cycles k+1..k+36 sampled on negedges.
  task automatic run_op(input string name, input logic [4:0] sel, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    int bad_busy, done_cnt, done_at;
    logic [31:0] res_at_done;
    bad_busy = 0; done_cnt = 0; done_at = -1; res_at_done = '0;
    @(negedge CLK);
    START = 1'b1; SELECT = sel; DATA1 = a; DATA2 = b;
    @(posedge CLK);
    for (int n = 1; n <= 36; n++) begin
      @(negedge CLK);
      if (n == 1) START = 1'b0;
      if (BUSY !== (n <= lat)) bad_busy++;
      if (DONE === 1'b1) begin
        done_cnt++;
        done_at = n;
        res_at_done = RESULT;
      end
    end
    check({name, "_busy_bad_cycles"}, bad_busy, 0);
    check({name, "_done_cycle"}, done_at, lat);
    check({name, "_done_count"}, done_cnt, 1);
    check({name, "_result"}, res_at_done, exp);
    check({name, "_result_hold"}, RESULT, exp);
  endtask

  initial begin
    int bad, dn;
    logic [31:0] saved, a, b;
    logic [4:0]  sel;

    vecs[0]  = '{ALU_DIV,  32'd100,        32'd7,          32'd14,         33};
    vecs[1]  = '{ALU_REM,  32'd100,        32'd7,          32'd2,          33};
    vecs[2]  = '{ALU_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33};
    vecs[3]  = '{ALU_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33};
    vecs[4]  = '{ALU_DIVU, 32'hFFFF_FFFF,  32'd2,          32'h7FFF_FFFF,  33};
    vecs[5]  = '{ALU_REMU, 32'hFFFF_FFFF,  32'd2,          32'd1,          33};
    vecs[6]  = '{ALU_DIV,  32'd5,          32'd0,          32'hFFFF_FFFF,  1};
    vecs[7]  = '{ALU_REM,  32'd5,          32'd0,          32'd5,          1};
    vecs[8]  = '{ALU_DIVU, 32'd0,          32'd0,          32'hFFFF_FFFF,  1};
    vecs[9]  = '{ALU_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1};
    vecs[10] = '{ALU_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1};
    vecs[11] = '{ALU_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          33};
    vecs[12] = '{ALU_DIV,  32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  33};
    vecs[13] = '{ALU_REM,  32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFFE,  33};
    vecs[14] = '{ALU_DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  33};
    vecs[15] = '{ALU_REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          33};

    RESET = 1'b0; START = 1'b0; FLUSH = 1'b0; SELECT = '0; DATA1 = '0; DATA2 = '0;
    repeat (2) @(negedge CLK);
    check("reset_busy", BUSY, 0);
    check("reset_done", DONE, 0);
    check("reset_result", RESULT, 0);
    RESET = 1'b1;

    for (int i = 0; i < 16; i++)
      run_op($sformatf("vec%0d", i), vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

    // FLUSH in cycle k+10 together with a fresh START.
    @(negedge CLK);
    START = 1'b1; SELECT = ALU_DIV; DATA1 = 32'd100; DATA2 = 32'd7;
    saved = RESULT;
    @(posedge CLK);
    for (int n = 1; n <= 10; n++) begin
      @(negedge CLK);
      if (n == 1) START = 1'b0;
    end
    check("flush_busy_before", BUSY, 1);
    FLUSH = 1'b1; START = 1'b1; SELECT = ALU_DIVU; DATA1 = 32'd50; DATA2 = 32'd3;
    @(negedge CLK);
    FLUSH = 1'b0; START = 1'b0;
    check("flush_busy_after", BUSY, 0);
    dn = 0; bad = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge CLK);
      if (DONE === 1'b1) dn++;
      if (BUSY !== 1'b0) bad++;
    end
    check("flush_no_done", dn, 0);
    check("flush_stays_idle", bad, 0);
    check("flush_result_kept", RESULT, saved);
    run_op("post_flush", ALU_DIVU, 32'd50, 32'd3, 32'd16, 33);

    // Non-divide select must be ignored.
    @(negedge CLK);
    START = 1'b1; SELECT = 5'b00001; DATA1 = 32'd9; DATA2 = 32'd3;
    bad = 0;
    for (int n = 0; n < 5; n++) begin
      @(negedge CLK);
      if (BUSY !== 1'b0 || DONE !== 1'b0) bad++;
    end
    START = 1'b0;
    check("add_ignored", bad, 0);

    // Asynchronous reset in the middle of CALC.
    @(negedge CLK);
    START = 1'b1; SELECT = ALU_DIV; DATA1 = 32'd100; DATA2 = 32'd7;
    @(posedge CLK);
    for (int n = 1; n <= 20; n++) begin
      @(negedge CLK);
      if (n == 1) START = 1'b0;
    end
    check("rst_busy_before", BUSY, 1);
    #2 RESET = 1'b0;
    #1;
    check("rst_async_busy", BUSY, 0);
    check("rst_async_done", DONE, 0);
    check("rst_async_result", RESULT, 0);
    @(negedge CLK);
    RESET = 1'b1;
    dn = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge CLK);
      if (DONE === 1'b1 || BUSY === 1'b1) dn++;
    end
    check("rst_no_done_after", dn, 0);
    run_op("post_reset", ALU_DIV, 32'd100, 32'd7, 32'd14, 33);

    // Random ops against the reference model.
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0: sel = ALU_DIV;
        1: sel = ALU_DIVU;
        2: sel = ALU_REM;
        default: sel = ALU_REMU;
      endcase
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: begin a = INT_MIN; b = ALL_ONES; end
        2: b = $urandom_range(1, 20);
        3: b = ALL_ONES - $urandom_range(0, 20);
        default: ;
      endcase
      run_op($sformatf("rnd%0d", i), sel, a, b, ref_div(sel, a, b), ref_lat(sel, a, b));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
